// File: rtl/instr_fetch_queue_pkg.sv
// Shared types and constants for the instruction fetch queue.
package instr_fetch_queue_pkg;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } ifq_state_e;

  // Wide enough for any practical NBITS; users slice the low bits.
  localparam logic [63:0] HALT_OPCODE = '1;
  localparam int unsigned PC_STEP     = 4;

endpackage

// File: rtl/instr_fetch_queue_fifo.sv
// ifq_fifo: small register FIFO with push/pop/flush, occupancy count and a
// registered head output that holds while nothing is popped.
module ifq_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_flush,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_data,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_data,
  output logic [$clog2(DEPTH):0]     o_count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             do_push, do_pop;

  assign do_pop  = i_pop && (count_q != '0) && !i_flush;
  assign do_push = i_push && !i_flush && ((count_q != CW'(DEPTH)) || do_pop);

  always_comb begin
    rd_d    = rd_q;
    wr_d    = wr_q;
    count_d = count_q;
    head_d  = head_q;
    if (i_flush) begin
      rd_d    = '0;
      wr_d    = '0;
      count_d = '0;
    end else begin
      if (do_pop)  rd_d = rd_q + PW'(1);
      if (do_push) wr_d = wr_q + PW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
      // The pushed word becomes the head when it lands in the slot being read.
      if (count_d != '0) begin
        if (do_push && (rd_d == wr_q)) head_d = i_data;
        else                           head_d = mem_q[rd_d];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
      head_q  <= '0;
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
      head_q  <= head_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (do_push) mem_q[wr_q] <= i_data;
  end

  assign o_data  = head_q;
  assign o_count = count_q;

endmodule

// File: rtl/instr_fetch_queue.sv
// Instruction memory with program-load port, PC sequencer and prefetch queue.
// Define IFQ_HALT_DETECT_EN to stop fetching when an all-ones word is enqueued.
module instr_fetch_queue
  import instr_fetch_queue_pkg::*;
#(
  parameter int               NBITS       = 32,
  parameter int               IMEM_DEPTH  = 256,
  parameter int               QUEUE_DEPTH = 4,
  parameter logic [NBITS-1:0] RESET_PC    = '0
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_load_en,
  input  logic                           i_load_valid,
  input  logic [NBITS-1:0]               i_load_data,
  input  logic                           i_flush,
  input  logic [NBITS-1:0]               i_flush_pc,
  input  logic                           i_ready,
  output logic                           o_valid,
  output logic [NBITS-1:0]               o_instr,
  output logic [NBITS-1:0]               o_pc,
  output logic [$clog2(QUEUE_DEPTH):0]   o_count,
  output logic                           o_halt
);
  localparam int AW = $clog2(IMEM_DEPTH);
  localparam int CW = $clog2(QUEUE_DEPTH) + 1;

`ifdef IFQ_HALT_DETECT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  ifq_state_e       state_q;
  logic [NBITS-1:0] pc_q;
  logic [AW-1:0]    ld_ptr_q;
  logic             inflight_q;
  logic             halt_q;
  logic [NBITS-1:0] imem_q [IMEM_DEPTH];
  logic [NBITS-1:0] rd_data_q, rd_pc_q;
  logic [CW-1:0]    count;
  logic [2*NBITS-1:0] head;
  logic             load_enter, load_exit, redirect, q_flush;
  logic             issue, push, halt_hit, load_wr;

  assign load_enter = i_load_en && (state_q != LOAD);
  assign load_exit  = !i_load_en && (state_q == LOAD);
  assign redirect   = i_flush && (state_q == RUN) && !i_load_en;
  assign q_flush    = load_enter || load_exit || redirect;
  assign load_wr    = (state_q == LOAD) && i_load_en && i_load_valid;

  // A read landing this cycle was issued last cycle; HALT and LOAD discard it.
  assign push     = inflight_q && (state_q == RUN);
  assign halt_hit = HALT_EN && push && (rd_data_q == HALT_OPCODE[NBITS-1:0]);
  assign issue    = (state_q == RUN) && !i_load_en && !i_flush &&
                    (({1'b0, count} + {{CW{1'b0}}, inflight_q}) < (CW+1)'(QUEUE_DEPTH));

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q    <= RUN;
      pc_q       <= RESET_PC;
      ld_ptr_q   <= '0;
      inflight_q <= 1'b0;
      halt_q     <= 1'b0;
    end else begin
      inflight_q <= issue;
      unique case (state_q)
        LOAD: begin
          if (!i_load_en) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
          end else if (i_load_valid) begin
            ld_ptr_q <= ld_ptr_q + AW'(1);
          end
        end
        RUN: begin
          if (i_load_en) begin
            state_q  <= LOAD;
            pc_q     <= RESET_PC;
            ld_ptr_q <= '0;
          end else if (i_flush) begin
            pc_q <= i_flush_pc;
          end else begin
            if (issue) pc_q <= pc_q + NBITS'(PC_STEP);
            if (halt_hit) begin
              state_q <= HALT;
              halt_q  <= 1'b1;
            end
          end
        end
        HALT: begin
          if (i_load_en) begin
            state_q  <= LOAD;
            pc_q     <= RESET_PC;
            ld_ptr_q <= '0;
            halt_q   <= 1'b0;
          end
        end
        default: state_q <= RUN;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (load_wr) imem_q[ld_ptr_q] <= i_load_data;
    if (issue) begin
      rd_data_q <= imem_q[pc_q[AW+1:2]];
      rd_pc_q   <= pc_q;
    end
  end

  ifq_fifo #(
    .WIDTH (2*NBITS),
    .DEPTH (QUEUE_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_flush (q_flush),
    .i_push  (push),
    .i_data  ({rd_pc_q, rd_data_q}),
    .i_pop   (i_ready),
    .o_data  (head),
    .o_count (count)
  );

  assign o_count = count;
  assign o_valid = (count != '0);
  assign o_pc    = head[2*NBITS-1:NBITS];
  assign o_instr = head[NBITS-1:0];
  assign o_halt  = HALT_EN & halt_q;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: directed vector table, reset/halt sequences and
// a randomized run checked against an in-order instruction stream model.
module tb_instr_fetch_queue;
  logic        clk = 1'b0;
  logic        rst, load_en, load_valid, flush, ready;
  logic [31:0] load_data, flush_pc;
  logic        o_valid, o_halt;
  logic [31:0] o_instr, o_pc;
  logic [2:0]  o_count;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] mdl_mem [256];
  logic [31:0] load_q [$];

  typedef struct {
    bit          reload;
    bit          rdy;
    bit          fl;
    logic [31:0] fpc;
    bit          ev;
    int          ec;
    logic [31:0] epc;
    logic [31:0] ein;
  } vec_t;

  vec_t vecs [20];

  instr_fetch_queue #(
    .NBITS(32), .IMEM_DEPTH(256), .QUEUE_DEPTH(4), .RESET_PC(32'h0)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_load_en(load_en), .i_load_valid(load_valid),
    .i_load_data(load_data), .i_flush(flush), .i_flush_pc(flush_pc),
    .i_ready(ready), .o_valid(o_valid), .o_instr(o_instr), .o_pc(o_pc),
    .o_count(o_count), .o_halt(o_halt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(bit rl, bit rdy, bit fl, logic [31:0] fpc,
                              bit ev, int ec, logic [31:0] epc, logic [31:0] ein);
    vec_t v;
    v.reload = rl; v.rdy = rdy; v.fl = fl; v.fpc = fpc;
    v.ev = ev; v.ec = ec; v.epc = epc; v.ein = ein;
    return v;
  endfunction

  task automatic do_load();
    @(negedge clk);
    load_en = 1'b1; load_valid = 1'b0; ready = 1'b0; flush = 1'b0;
    for (int i = 0; i < load_q.size(); i++) begin
      @(negedge clk);
      load_valid = 1'b1;
      load_data  = load_q[i];
      mdl_mem[i % 256] = load_q[i];
    end
    @(negedge clk);
    load_valid = 1'b0;
    load_en    = 1'b0;
  endtask

  initial begin
    logic [31:0] exp_pc, prev_pc, prev_instr, w;
    bit          hold_prev;
    int          ndeq;

    rst = 1'b0; load_en = 1'b0; load_valid = 1'b0; load_data = '0;
    flush = 1'b0; flush_pc = '0; ready = 1'b0;

    // Throughput after load, then fill/saturate/flush while full.
    vecs[0]  = mk(1, 1, 0, 0,     0, 0, 0,  0);
    vecs[1]  = mk(0, 1, 0, 0,     0, 0, 0,  0);
    vecs[2]  = mk(0, 1, 0, 0,     1, 1, 0,  32'h11);
    vecs[3]  = mk(0, 1, 0, 0,     1, 1, 4,  32'h22);
    vecs[4]  = mk(0, 1, 0, 0,     1, 1, 8,  32'h33);
    vecs[5]  = mk(0, 1, 0, 0,     1, 1, 12, 32'h44);
    vecs[6]  = mk(1, 0, 0, 0,     0, 0, 0,  0);
    vecs[7]  = mk(0, 0, 0, 0,     0, 0, 0,  0);
    vecs[8]  = mk(0, 0, 0, 0,     1, 1, 0,  32'h11);
    vecs[9]  = mk(0, 0, 0, 0,     1, 2, 0,  32'h11);
    vecs[10] = mk(0, 0, 0, 0,     1, 3, 0,  32'h11);
    vecs[11] = mk(0, 0, 0, 0,     1, 4, 0,  32'h11);
    vecs[12] = mk(0, 1, 1, 32'h8, 1, 4, 0,  32'h11);
    vecs[13] = mk(0, 1, 0, 0,     0, 0, 0,  0);
    vecs[14] = mk(0, 1, 0, 0,     0, 0, 0,  0);
    vecs[15] = mk(0, 1, 0, 0,     1, 1, 8,  32'h33);
    vecs[16] = mk(0, 1, 0, 0,     1, 1, 12, 32'h44);
    vecs[17] = mk(0, 1, 0, 0,     1, 1, 16, 32'h55);
    vecs[18] = mk(0, 0, 0, 0,     1, 1, 20, 32'h66);
    vecs[19] = mk(0, 0, 0, 0,     1, 2, 20, 32'h66);

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_valid", {31'b0, o_valid}, 32'd0);
    check("rst_count", 32'(o_count), 32'd0);
    check("rst_pc", o_pc, 32'd0);
    check("rst_instr", o_instr, 32'd0);
    check("rst_halt", {31'b0, o_halt}, 32'd0);
    rst = 1'b1;

    load_q = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h55, 32'h66, 32'h77, 32'h88};
    for (int i = 0; i < 20; i++) begin
      if (vecs[i].reload) do_load();
      @(negedge clk);
      $display("vec %0d: valid=%0b count=%0d pc=%h instr=%h", i, o_valid, o_count, o_pc, o_instr);
      check($sformatf("vec%0d_valid", i), {31'b0, o_valid}, {31'b0, vecs[i].ev});
      check($sformatf("vec%0d_count", i), 32'(o_count), 32'(vecs[i].ec));
      if (vecs[i].ev) begin
        check($sformatf("vec%0d_pc", i), o_pc, vecs[i].epc);
        check($sformatf("vec%0d_instr", i), o_instr, vecs[i].ein);
      end
      ready = vecs[i].rdy; flush = vecs[i].fl; flush_pc = vecs[i].fpc;
    end

    // One-cycle reset mid-stream: memory survives, fetch restarts at 0.
    @(negedge clk); rst = 1'b0; ready = 1'b1; flush = 1'b0;
    @(negedge clk);
    $display("reset: valid=%0b count=%0d pc=%h instr=%h", o_valid, o_count, o_pc, o_instr);
    check("mid_rst_valid", {31'b0, o_valid}, 32'd0);
    check("mid_rst_count", 32'(o_count), 32'd0);
    check("mid_rst_pc", o_pc, 32'd0);
    check("mid_rst_instr", o_instr, 32'd0);
    check("mid_rst_halt", {31'b0, o_halt}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("restart_idle", {31'b0, o_valid}, 32'd0);
    @(negedge clk);
    check("restart_pc0", o_pc, 32'd0);
    check("restart_instr0", o_instr, 32'h11);
    @(negedge clk);
    check("restart_pc1", o_pc, 32'd4);
    check("restart_instr1", o_instr, 32'h22);

`ifdef IFQ_HALT_DETECT_EN
    load_q = '{32'h11, 32'h22, 32'hFFFF_FFFF, 32'h44};
    do_load();
    ndeq = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      ready = 1'b1;
      if (o_valid) begin
        $display("halt deq: pc=%h instr=%h halt=%0b", o_pc, o_instr, o_halt);
        if (ndeq < 3) begin
          check("halt_deq_pc", o_pc, 32'(ndeq * 4));
          check("halt_deq_instr", o_instr, load_q[ndeq]);
        end
        ndeq++;
      end
    end
    check("halt_deq_total", 32'(ndeq), 32'd3);
    check("halt_flag", {31'b0, o_halt}, 32'd1);
    check("halt_drained", {31'b0, o_valid}, 32'd0);
    @(negedge clk); flush = 1'b1; flush_pc = 32'h0;
    @(negedge clk); flush = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("halt_flush_ignored", {31'b0, o_valid}, 32'd0);
    end
    check("halt_held", {31'b0, o_halt}, 32'd1);
`endif

    // Randomized run against the in-order stream model.
    load_q.delete();
    for (int i = 0; i < 260; i++) begin
      w = $urandom;
`ifdef IFQ_HALT_DETECT_EN
      if (w == 32'hFFFF_FFFF) w = 32'h0;
`else
      if (i == 5) w = 32'hFFFF_FFFF;
`endif
      load_q.push_back(w);
    end
    do_load();
    exp_pc = 32'h0; hold_prev = 1'b0; ndeq = 0;
    prev_pc = '0; prev_instr = '0;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      check("rnd_valid_vs_count", {31'b0, o_valid}, {31'b0, (o_count != 3'd0)});
      check("rnd_count_range", {31'b0, (o_count > 3'd4)}, 32'd0);
      check("rnd_halt_low", {31'b0, o_halt}, 32'd0);
      if (hold_prev) begin
        check("rnd_hold_valid", {31'b0, o_valid}, 32'd1);
        check("rnd_hold_pc", o_pc, prev_pc);
        check("rnd_hold_instr", o_instr, prev_instr);
      end
      ready = ($urandom_range(0, 99) < 70);
      flush = ($urandom_range(0, 99) < 4);
      if ($urandom_range(0, 9) == 0) flush_pc = 32'hFFFF_FFF0 + ($urandom & 32'hF);
      else                           flush_pc = $urandom & 32'h3FF;
      if (flush) begin
        exp_pc = flush_pc;
      end else if (o_valid && ready) begin
        $display("deq %0d: pc=%h instr=%h", ndeq, o_pc, o_instr);
        check("rnd_deq_pc", o_pc, exp_pc);
        check("rnd_deq_instr", o_instr, mdl_mem[exp_pc[9:2]]);
        exp_pc = exp_pc + 32'd4;
        ndeq++;
      end
      hold_prev  = o_valid && !ready && !flush;
      prev_pc    = o_pc;
      prev_instr = o_instr;
    end
    check("rnd_progress", {31'b0, (ndeq > 500)}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
